// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-access stage.
//   - funct3 load/store size encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - memory-access FSM state encoding
//   - f3_misaligned(): alignment rule for a given funct3 and byte offset
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StWait = 1'b1
   } mem_state_e;

   // Unsupported sizes (011/110/111) are reported as misaligned so they never reach memory.
   function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
      logic mis;
      unique case (funct3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = addr[0];
         F3_W:        mis = (addr != 2'b00);
         default:     mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment and extension.
//   rdata_i    : 32-bit word returned by data memory
//   addr_i     : byte offset within the word
//   funct3_i   : load size/sign (LB, LH, LW, LBU, LHU)
//   load_ext_o : selected byte/half, sign- or zero-extended; word passes through
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] load_ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      unique case (addr_i)
         2'b00: byte_sel = rdata_i[7:0];
         2'b01: byte_sel = rdata_i[15:8];
         2'b10: byte_sel = rdata_i[23:16];
         2'b11: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      load_ext_o = rdata_i;
      unique case (funct3_i)
         F3_B:    load_ext_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_ext_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_ext_o = {24'd0, byte_sel};
         F3_HU:   load_ext_o = {16'd0, half_sel};
         default: load_ext_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register.
//   Inputs from EX/MEM : alu_result_in, rd2_in, rd_in, funct3_in, RegWrite_in, MemtoReg_in,
//                        MemRead_in, MemWrite_in
//   Data-memory bus    : dmem_req/we/addr/wdata/be out, dmem_ready/rdata in
//   Pipeline control   : stall_out holds EX/MEM and earlier stages
//   MEM/WB register    : wb_data_out, rd_out, RegWrite_out, misalign_out
// Optional: define MEM_WB_STAGE_STALL_CNT_EN to add the stall_cycles performance counter.
module mem_wb_stage
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] rd2_in,
   input  logic [4:0]        rd_in,
   input  logic [2:0]        funct3_in,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ready,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [4:0]        rd_out,
   output logic              RegWrite_out,
   output logic              misalign_out
`ifdef MEM_WB_STAGE_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   mem_state_e        state_q, state_d;
   logic              mem_acc, misaligned, mem_op;
   logic [1:0]        byte_off;
   logic [31:0]       load_ext;
   logic [DATA_W-1:0] wb_data_q;
   logic [4:0]        rd_q;
   logic              regwrite_q, misalign_q;

   assign byte_off   = alu_result_in[1:0];
   assign mem_acc    = MemRead_in | MemWrite_in;
   assign misaligned = mem_acc & f3_misaligned(funct3_in, byte_off);
   assign mem_op     = mem_acc & ~misaligned;
   assign stall_out  = mem_op & ~dmem_ready;

   // Access FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dmem_req = mem_op;
      unique case (state_q)
         StIdle: begin
            if (mem_op && !dmem_ready) state_d = StWait;
         end
         StWait: begin
            // Upstream holds the request stable while stalled.
            dmem_req = 1'b1;
            if (dmem_ready) state_d = StIdle;
         end
      endcase
   end

   // Bus drive: address, direction, byte enables and lane-replicated store data
   assign dmem_we   = MemWrite_in;
   assign dmem_addr = {alu_result_in[ADDR_W-1:2], 2'b00};

   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = rd2_in;
      if (MemWrite_in) begin
         unique case (funct3_in[1:0])
            2'b00: begin
               dmem_be    = 4'b0001 << byte_off;
               dmem_wdata = {4{rd2_in[7:0]}};
            end
            2'b01: begin
               dmem_be    = byte_off[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{rd2_in[15:0]}};
            end
            default: begin
               dmem_be    = 4'b1111;
               dmem_wdata = rd2_in;
            end
         endcase
      end
   end

   load_align u_load_align (
      .rdata_i    (dmem_rdata),
      .addr_i     (byte_off),
      .funct3_i   (funct3_in),
      .load_ext_o (load_ext)
   );

   // MEM/WB register; a stall inserts a bubble and holds the data field.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_data_q  <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         misalign_q <= 1'b0;
      end else if (stall_out) begin
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         wb_data_q  <= MemtoReg_in ? load_ext : alu_result_in;
         rd_q       <= rd_in;
         regwrite_q <= RegWrite_in & ~misaligned;
         misalign_q <= misaligned;
      end
   end

   assign wb_data_out  = wb_data_q;
   assign rd_out       = rd_q;
   assign RegWrite_out = regwrite_q;
   assign misalign_out = misalign_q;

`ifdef MEM_WB_STAGE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (stall_out) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized operations with
// random memory latency, checked against an arithmetic reference model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] alu_result_in, rd2_in;
   logic [4:0]  rd_in;
   logic [2:0]  funct3_in;
   logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        stall_out;
   logic [31:0] wb_data_out;
   logic [4:0]  rd_out;
   logic        RegWrite_out, misalign_out;
`ifdef MEM_WB_STAGE_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .alu_result_in (alu_result_in),
      .rd2_in        (rd2_in),
      .rd_in         (rd_in),
      .funct3_in     (funct3_in),
      .RegWrite_in   (RegWrite_in),
      .MemtoReg_in   (MemtoReg_in),
      .MemRead_in    (MemRead_in),
      .MemWrite_in   (MemWrite_in),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_be       (dmem_be),
      .dmem_ready    (dmem_ready),
      .dmem_rdata    (dmem_rdata),
      .stall_out     (stall_out),
      .wb_data_out   (wb_data_out),
      .rd_out        (rd_out),
      .RegWrite_out  (RegWrite_out),
      .misalign_out  (misalign_out)
`ifdef MEM_WB_STAGE_STALL_CNT_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: access size in bytes, 0 for an unsupported funct3.
   function automatic int f3_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                            input int off);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   // One EX/MEM operation held until it completes; lat = wait cycles before dmem_ready.
   task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input bit rw, input logic [31:0] rdata,
                        input int lat);
      int          size, off, n;
      bit          mem, mis, op, exp_stall;
      logic [31:0] exp_be, exp_wdata, exp_wb;
      off  = int'(addr % 4);
      size = f3_size(f3);
      mem  = ld || st;
      mis  = mem && (size == 0 || (off % size) != 0);
      op   = mem && !mis;
      n    = op ? lat : 0;
      exp_be    = 32'hF;
      exp_wdata = sdata;
      if (st && size == 1) begin
         exp_be    = 32'd1 << off;
         exp_wdata = (sdata & 32'hFF) * 32'h01010101;
      end else if (st && size == 2) begin
         exp_be    = 32'd3 << (2 * (off / 2));
         exp_wdata = (sdata & 32'hFFFF) * 32'h00010001;
      end
      exp_wb = ld ? ref_load(f3, rdata, off) : addr;
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         alu_result_in = addr;
         rd2_in        = sdata;
         rd_in         = rd;
         funct3_in     = f3;
         RegWrite_in   = rw;
         MemtoReg_in   = ld;
         MemRead_in    = ld;
         MemWrite_in   = st;
         dmem_rdata    = (k == n) ? rdata : $urandom;
         dmem_ready    = op ? (k == n) : 1'($urandom_range(0, 1));
         exp_stall     = op && (k < n);
         #1;
         check("dmem_req", 32'(dmem_req), 32'(op));
         check("stall_out", 32'(stall_out), 32'(exp_stall));
         if (op) begin
            check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("dmem_we", 32'(dmem_we), 32'(st));
            check("dmem_be", 32'(dmem_be), exp_be);
            if (st) check("dmem_wdata", dmem_wdata, exp_wdata);
         end
         @(posedge clk);
         #1;
         if (exp_stall) begin
            check("bubble_rw", 32'(RegWrite_out), 32'd0);
            check("bubble_rd", 32'(rd_out), 32'd0);
            check("bubble_mis", 32'(misalign_out), 32'd0);
         end else begin
            check("rd_out", 32'(rd_out), 32'(rd));
            check("RegWrite_out", 32'(RegWrite_out), 32'(rw && !mis));
            check("misalign_out", 32'(misalign_out), 32'(mis));
            if (!(ld && mis)) check("wb_data_out", wb_data_out, exp_wb);
         end
      end
   endtask

   initial begin
      bit          ld, st;
      logic [2:0]  f3;
`ifdef MEM_WB_STAGE_STALL_CNT_EN
      logic [31:0] cnt0;
`endif
      reset_n       = 1'b0;
      alu_result_in = '0;
      rd2_in        = '0;
      rd_in         = '0;
      funct3_in     = '0;
      RegWrite_in   = 1'b0;
      MemtoReg_in   = 1'b0;
      MemRead_in    = 1'b0;
      MemWrite_in   = 1'b0;
      dmem_ready    = 1'b0;
      dmem_rdata    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb_data", wb_data_out, 32'd0);
      check("rst_rd", 32'(rd_out), 32'd0);
      check("rst_rw", 32'(RegWrite_out), 32'd0);
      check("rst_mis", 32'(misalign_out), 32'd0);
      check("rst_req", 32'(dmem_req), 32'd0);
`ifdef MEM_WB_STAGE_STALL_CNT_EN
      check("rst_stall_cnt", stall_cycles, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      // Directed cases
      do_op(0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 32'h0, 0);         // ALU op
      do_op(0, 1, 3'd0, 32'h103, 32'hAB, 5'd0, 0, 32'h0, 0);         // SB
      do_op(1, 0, 3'd0, 32'h102, 32'h0, 5'd7, 1, 32'h0080_0000, 3);  // LB
      do_op(1, 0, 3'd4, 32'h102, 32'h0, 5'd7, 1, 32'h0080_0000, 3);  // LBU
      do_op(1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 1, 32'h0, 2);          // misaligned LW
      do_op(0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd0, 0, 32'h0, 1);  // SH upper
      do_op(1, 0, 3'd5, 32'h206, 32'h0, 5'd3, 1, 32'h8001_7FFF, 0);  // LHU upper
      do_op(1, 0, 3'd6, 32'h300, 32'h0, 5'd4, 1, 32'h0, 0);          // illegal funct3

      // Reset while waiting on memory
      do_op(0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 32'h0, 0);
      @(negedge clk);
      alu_result_in = 32'h200;
      funct3_in     = 3'd2;
      rd_in         = 5'd6;
      RegWrite_in   = 1'b1;
      MemtoReg_in   = 1'b1;
      MemRead_in    = 1'b1;
      MemWrite_in   = 1'b0;
      dmem_ready    = 1'b0;
      #1;
      check("wait_stall", 32'(stall_out), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("arst_wb_data", wb_data_out, 32'd0);
      check("arst_rd", 32'(rd_out), 32'd0);
      check("arst_rw", 32'(RegWrite_out), 32'd0);
      check("arst_mis", 32'(misalign_out), 32'd0);
      MemRead_in  = 1'b0;
      MemtoReg_in = 1'b0;
      #1;
      check("arst_req", 32'(dmem_req), 32'd0);
      check("arst_stall", 32'(stall_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_req", 32'(dmem_req), 32'd0);

`ifdef MEM_WB_STAGE_STALL_CNT_EN
      cnt0 = stall_cycles;
      do_op(1, 0, 3'd2, 32'h40, 32'h0, 5'd1, 1, 32'h1111_2222, 2);
      do_op(1, 0, 3'd2, 32'h44, 32'h0, 5'd2, 1, 32'h3333_4444, 5);
      check("stall_cycles", stall_cycles - cnt0, 32'd7);
`endif

      // Randomized operations
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 2))
            0:       begin ld = 0; st = 0; end
            1:       begin ld = 1; st = 0; end
            default: begin ld = 0; st = 1; end
         endcase
         f3 = 3'($urandom_range(0, 7));
         if (st && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
         do_op(ld, st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
               !st && ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; consumes the EX/MEM register outputs.
- Drives a request/ready data-memory bus and performs RV32I load/store sizing: byte enables, store-lane replication, load sign/zero extension.
- Stalls upstream while a memory access is outstanding.
- Registers writeback data, destination register and RegWrite for the WB stage and the forwarding unit.

Parameters:
- ADDR_W, 32, width of dmem_addr; the low ADDR_W bits of alu_result_in are used.
- DATA_W, 32, data width; fixed at 32 for this revision, other values unsupported.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- alu_result_in  in  32  ALU result from EX/MEM: address for loads/stores, writeback value otherwise
- rd2_in  in  32  store data
- rd_in  in  5  destination register
- funct3_in  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control from EX/MEM
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  word-aligned address {alu_result_in[ADDR_W-1:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete this cycle; dmem_rdata valid when dmem_we=0
- dmem_rdata  in  32  read word
- stall_out  out  1  hold EX/MEM and all earlier stages this cycle
- wb_data_out  out  32  registered writeback value
- rd_out  out  5  registered destination register
- RegWrite_out  out  1  registered write enable
- misalign_out  out  1  registered misaligned-access flag

Behaviour:
- Reset (reset_n=0, async): FSM=IDLE; wb_data_out=0, rd_out=0, RegWrite_out=0, misalign_out=0. Combinational outputs follow the rules below with FSM=IDLE.
- mem_op = (MemRead_in|MemWrite_in) & ~misaligned.
- misaligned:
  - halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - Byte accesses never misalign.
  - funct3 011/110/111 with MemRead or MemWrite is treated as misaligned.
- FSM states: IDLE, WAIT.
- IDLE:
  - dmem_req = mem_op, combinational, same cycle as the inputs.
  - mem_op & dmem_ready: zero-wait completion; stay IDLE.
  - mem_op & ~dmem_ready: go to WAIT.
- WAIT:
  - dmem_req=1; dmem_addr, dmem_we, dmem_be and dmem_wdata are driven from the inputs, which upstream holds stable.
  - dmem_ready: completion; go to IDLE.
- stall_out = mem_op & ~dmem_ready, in either state.
- MEM/WB register update, every posedge:
  - stall_out=1: load a bubble (RegWrite_out=0, rd_out=0, misalign_out=0); wb_data_out is don't-care, held.
  - otherwise: rd_out=rd_in; RegWrite_out = RegWrite_in & ~misaligned; misalign_out=misaligned; wb_data_out = MemtoReg_in ? load_ext : alu_result_in.
- Byte enables (addr = alu_result_in[1:0]):
  - SB: 1<<addr.
  - SH: addr[1] ? 1100 : 0011.
  - SW: 1111.
  - Loads: dmem_be=1111.
- Store data:
  - SB: {4{rd2_in[7:0]}}.
  - SH: {2{rd2_in[15:0]}}.
  - SW: rd2_in.
- Load extension: select byte/half from dmem_rdata by addr; sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes dmem_rdata unchanged.
- Misaligned access: no dmem_req, no stall, no register write; misalign_out=1 for one cycle.
- Reset mid-WAIT: FSM returns to IDLE immediately; the outstanding access is abandoned. The memory model must tolerate a dropped request.
- Each operation produces exactly one completion. A new operation may be issued the cycle after a completion.

Optional Feature:
- Macro: MEM_WB_STAGE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [31:0].
  - Increments on every cycle with stall_out=1; wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Shared package (riscv_pkg): funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and FSM state encoding.
- One sub-module, load_align: combinational, takes dmem_rdata, addr[1:0] and funct3, produces load_ext.
- FSM, byte enables, store data and MEM/WB register stay in mem_wb_stage.

Test Plan:
- Reset then ALU op: RegWrite_in=1, rd_in=5, alu_result_in=0x1234, no mem op -> next edge wb_data_out=0x1234, rd_out=5, RegWrite_out=1, dmem_req never asserted.
- SB: addr 0x103, rd2_in=0x000000AB, dmem_ready=1 same cycle -> dmem_addr=0x100, dmem_be=1000, dmem_wdata=0xABABABAB, stall_out=0.
- LB: addr 0x102, dmem_rdata=0x00800000, ready after 3 cycles -> stall_out=1 for 3 cycles with bubbles in MEM/WB, then wb_data_out=0xFFFFFF80. Same stimulus as LBU -> 0x00000080.
- LW at 0x101 -> no dmem_req, RegWrite_out=0, misalign_out=1 for one cycle.
- reset_n low during WAIT -> FSM=IDLE, all registered outputs 0 asynchronously, dmem_req=0 while reset held with MemRead_in=0.
- With MEM_WB_STAGE_STALL_CNT_EN: two loads with 2 and 5 wait cycles -> stall_cycles=7.
